// File: rtl/yuv2rgb.sv
// Signed Y/U/V component stream to clamped unsigned R/G/B: a 3-state collector assembles
// each triple, then a never-stalling multiply / sum / clamp pipeline emits one pixel per triple.
module yuv2rgb #(
  parameter int IN_WIDTH   = 8,
  parameter int COEF_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_first,
  input  logic [IN_WIDTH-1:0] in_data,
  output logic                out_valid,
  output logic [IN_WIDTH-1:0] R,
  output logic [IN_WIDTH-1:0] G,
  output logic [IN_WIDTH-1:0] B,
  output logic                sync_err
);

  localparam int PW = IN_WIDTH + COEF_WIDTH;
  localparam int SW = 20;

  localparam logic signed [COEF_WIDTH-1:0] KRV = COEF_WIDTH'(359);
  localparam logic signed [COEF_WIDTH-1:0] KGU = COEF_WIDTH'(-88);
  localparam logic signed [COEF_WIDTH-1:0] KGV = COEF_WIDTH'(-183);
  localparam logic signed [COEF_WIDTH-1:0] KBU = COEF_WIDTH'(454);
  localparam logic signed [PW-1:0] KRV_X = PW'(KRV);
  localparam logic signed [PW-1:0] KGU_X = PW'(KGU);
  localparam logic signed [PW-1:0] KGV_X = PW'(KGV);
  localparam logic signed [PW-1:0] KBU_X = PW'(KBU);

  typedef enum logic [1:0] {S_Y, S_U, S_V} state_t;

  state_t state_q, state_d;
  logic signed [IN_WIDTH-1:0] y_q, y_d, u_q, u_d, v_q, v_d;
  logic launch_q, launch_d;
  logic sync_q, sync_d;

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    u_d      = u_q;
    v_d      = v_q;
    launch_d = 1'b0;
    sync_d   = 1'b0;
    if (in_valid) begin
      case (state_q)
        S_Y: begin
          y_d     = in_data;
          state_d = S_U;
        end
        S_U, S_V: begin
          if (in_first) begin
            // Early Y: drop the partial triple and restart with this beat as Y.
            y_d     = in_data;
            state_d = S_U;
            sync_d  = 1'b1;
          end else if (state_q == S_U) begin
            u_d     = in_data;
            state_d = S_V;
          end else begin
            v_d      = in_data;
            launch_d = 1'b1;
            state_d  = S_Y;
          end
        end
        default: state_d = S_Y;
      endcase
    end
  end

  // Stage 1 operands: holding registers are stable for the cycle after launch.
  logic signed [PW-1:0] u_x, v_x;
  logic signed [SW-1:0] ybase_d;
  assign u_x = PW'(u_q);
  assign v_x = PW'(v_q);
  // (Y + 128) * 256 + 128: flipping the sign bit gives the offset-binary Y'.
  assign ybase_d = {{(SW-2*IN_WIDTH){1'b0}}, ~y_q[IN_WIDTH-1], y_q[IN_WIDTH-2:0],
                    1'b1, {(IN_WIDTH-1){1'b0}}};

  logic                 p1_vld_q, p2_vld_q, out_vld_q;
  logic signed [PW-1:0] prv_q, pgu_q, pgv_q, pbu_q;
  logic signed [SW-1:0] ybase_q, sr_q, sg_q, sb_q;
  logic [IN_WIDTH-1:0]  r_q, g_q, b_q;

  function automatic logic [IN_WIDTH-1:0] clamp_px(input logic signed [SW-1:0] s);
    if (s[SW-1])
      return '0;
    else if (|s[SW-2:2*IN_WIDTH])
      return '1;
    else
      return s[2*IN_WIDTH-1:IN_WIDTH];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_Y;
      y_q       <= '0;
      u_q       <= '0;
      v_q       <= '0;
      launch_q  <= 1'b0;
      sync_q    <= 1'b0;
      p1_vld_q  <= 1'b0;
      p2_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      prv_q     <= '0;
      pgu_q     <= '0;
      pgv_q     <= '0;
      pbu_q     <= '0;
      ybase_q   <= '0;
      sr_q      <= '0;
      sg_q      <= '0;
      sb_q      <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      u_q       <= u_d;
      v_q       <= v_d;
      launch_q  <= launch_d;
      sync_q    <= sync_d;
      p1_vld_q  <= launch_q;
      p2_vld_q  <= p1_vld_q;
      out_vld_q <= p2_vld_q;
      if (launch_q) begin
        prv_q   <= KRV_X * v_x;
        pgu_q   <= KGU_X * u_x;
        pgv_q   <= KGV_X * v_x;
        pbu_q   <= KBU_X * u_x;
        ybase_q <= ybase_d;
      end
      if (p1_vld_q) begin
        sr_q <= ybase_q + SW'(prv_q);
        sg_q <= ybase_q + SW'(pgu_q) + SW'(pgv_q);
        sb_q <= ybase_q + SW'(pbu_q);
      end
      if (p2_vld_q) begin
        r_q <= clamp_px(sr_q);
        g_q <= clamp_px(sg_q);
        b_q <= clamp_px(sb_q);
      end
    end
  end

  assign out_valid = out_vld_q;
  assign sync_err  = sync_q;
  assign R         = r_q;
  assign G         = g_q;
  assign B         = b_q;

endmodule
